// File: rtl/regfile_sb.sv
// Integer register file with a per-register busy scoreboard for RAW-hazard stalls.
// Two combinational read ports (optional write-through bypass), one writeback, one issue port.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wen,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] din,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] r1,
  output logic [XLEN-1:0] r2,
  output logic            r1_rdy,
  output logic            r2_rdy,
  output logic [AW:0]     busy_cnt
);

  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic [AW:0]      cnt_r;
  logic             wr_ok_s;
  logic             set_s;
  logic             clr_s;

  assign wr_ok_s = wen && !(ZERO_REG && (rd == ZERO_IDX));

  // A newly set bit raises the count, a cleared bit lowers it; issue wins over writeback on one index.
  assign set_s = !flush && iss_en && !(ZERO_REG && (iss_rd == ZERO_IDX)) && !busy_r[iss_rd];
  assign clr_s = !flush && wen && busy_r[rd] && !(iss_en && (iss_rd == rd));

  // Register array storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[rd] <= din;
    end
  end

  // Scoreboard next state: flush, then issue, then writeback
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      if (flush || (ZERO_REG && (i == 0))) begin
        busy_next_s[i] = 1'b0;
      end else if (iss_en && (iss_rd == AW'(i))) begin
        busy_next_s[i] = 1'b1;
      end else if (wen && (rd == AW'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
    end
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Busy count tracked incrementally alongside the scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      cnt_r <= {(AW+1){1'b0}};
    end else begin
      case ({set_s, clr_s})
        2'b10:   cnt_r <= cnt_r + {{AW{1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{AW{1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign busy_cnt = cnt_r;

  // Read port 1
  always_comb begin
    r1     = regs_r[rs1];
    r1_rdy = !busy_r[rs1];
    if (ZERO_REG && (rs1 == ZERO_IDX)) begin
      r1     = {XLEN{1'b0}};
      r1_rdy = 1'b1;
    end else if (BYPASS && wen && (rd == rs1)) begin
      r1     = din;
      r1_rdy = 1'b1;
    end else begin
      r1     = regs_r[rs1];
      r1_rdy = !busy_r[rs1];
    end
  end

  // Read port 2
  always_comb begin
    r2     = regs_r[rs2];
    r2_rdy = !busy_r[rs2];
    if (ZERO_REG && (rs2 == ZERO_IDX)) begin
      r2     = {XLEN{1'b0}};
      r2_rdy = 1'b1;
    end else if (BYPASS && wen && (rd == rs2)) begin
      r2     = din;
      r2_rdy = 1'b1;
    end else begin
      r2     = regs_r[rs2];
      r2_rdy = !busy_r[rs2];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic, checked against an array/vector model.
// A BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wen = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] din = 32'd0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_rd = 5'd0;
  logic        flush = 1'b0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;

  logic [31:0] r1, r2, n1, n2;
  logic        r1_rdy, r2_rdy, n1_rdy, n2_rdy;
  logic [5:0]  busy_cnt, nb_busy_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .rd(rd), .din(din),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .rs1(rs1), .rs2(rs2),
    .r1(r1), .r2(r2), .r1_rdy(r1_rdy), .r2_rdy(r2_rdy), .busy_cnt(busy_cnt));

  regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wen(wen), .rd(rd), .din(din),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .rs1(rs1), .rs2(rs2),
    .r1(n1), .r2(n2), .r1_rdy(n1_rdy), .r2_rdy(n2_rdy), .busy_cnt(nb_busy_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: later assignment wins, so issue overrides writeback on the same index
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_busy <= 32'd0;
    end else begin
      if (wen && rd != 5'd0) m_regs[rd] <= din;
      if (flush) begin
        m_busy <= 32'd0;
      end else begin
        if (wen) m_busy[rd] <= 1'b0;
        if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] <= 1'b1;
      end
    end
  end

  function automatic logic [32:0] exp_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return {1'b1, 32'd0};
    if (byp && wen && rd == idx) return {1'b1, din};
    return {~m_busy[idx], m_regs[idx]};
  endfunction

  // Compare process: every falling edge, with inputs stable and state settled
  always @(negedge clk) begin
    if (check_en) begin
      logic [32:0] e;
      e = exp_read(rs1, 1'b1);
      check("r1", r1, e[31:0]);       check("r1_rdy", {31'd0, r1_rdy}, {31'd0, e[32]});
      e = exp_read(rs2, 1'b1);
      check("r2", r2, e[31:0]);       check("r2_rdy", {31'd0, r2_rdy}, {31'd0, e[32]});
      e = exp_read(rs1, 1'b0);
      check("nb_r1", n1, e[31:0]);    check("nb_r1_rdy", {31'd0, n1_rdy}, {31'd0, e[32]});
      e = exp_read(rs2, 1'b0);
      check("nb_r2", n2, e[31:0]);    check("nb_r2_rdy", {31'd0, n2_rdy}, {31'd0, e[32]});
      check("busy_cnt", {26'd0, busy_cnt}, $countones(m_busy));
      check("nb_busy_cnt", {26'd0, nb_busy_cnt}, $countones(m_busy));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #1;
    rst_n = 1'b0;
    wen = 1'b1; rd = 5'd7; din = 32'hDEADBEEF; rs1 = 5'd5; rs2 = 5'd31;
    check_en = 1'b1;
    repeat (2) cyc();
    check("rst_cnt", {26'd0, busy_cnt}, 32'd0);
    check("rst_r1", r1, 32'd0);
    check("rst_r2_rdy", {31'd0, r2_rdy}, 32'd1);
    rst_n = 1'b1; idle(); rs1 = 5'd7;
    #1 check("rst_reg7", r1, 32'd0);
    cyc();

    // Bypass: BYPASS=1 forwards immediately, BYPASS=0 shows the old value until after the edge
    wen = 1'b1; rd = 5'd3; din = 32'h1234; rs1 = 5'd3;
    #1 check("byp_r1", r1, 32'h1234);
    check("nobyp_r1_old", n1, 32'd0);
    cyc(); idle();
    #1 check("nobyp_r1_new", n1, 32'h1234);

    wen = 1'b1; rd = 5'd0; din = 32'hFFFF_FFFF;
    cyc(); idle(); rs2 = 5'd0;
    #1 check("zero_r2", r2, 32'd0);

    // Scoreboard lifecycle
    iss_en = 1'b1; iss_rd = 5'd10; rs1 = 5'd10;
    #1 check("iss_same_cycle_rdy", {31'd0, r1_rdy}, 32'd1);
    cyc(); idle();
    check("iss_rdy", {31'd0, r1_rdy}, 32'd0);
    check("iss_cnt", {26'd0, busy_cnt}, 32'd1);
    wen = 1'b1; rd = 5'd10; din = 32'hA5;
    #1 check("wb_byp_r1", r1, 32'hA5);
    check("wb_byp_rdy", {31'd0, r1_rdy}, 32'd1);
    cyc(); idle();
    check("wb_cnt", {26'd0, busy_cnt}, 32'd0);

    // Simultaneous set and clear
    iss_en = 1'b1; iss_rd = 5'd4;
    cyc();
    wen = 1'b1; rd = 5'd4; din = 32'h55;
    cyc(); idle(); rs1 = 5'd4;
    #1 check("sim_r4", r1, 32'h55);
    check("sim_rdy4", {31'd0, r1_rdy}, 32'd0);
    check("sim_cnt", {26'd0, busy_cnt}, 32'd1);
    iss_en = 1'b1; iss_rd = 5'd6; wen = 1'b1; rd = 5'd4; din = 32'h66;
    cyc(); idle(); rs2 = 5'd6;
    #1 check("pm_cnt", {26'd0, busy_cnt}, 32'd1);
    check("pm_rdy4", {31'd0, r1_rdy}, 32'd1);
    check("pm_rdy6", {31'd0, r2_rdy}, 32'd0);

    // Flush drops a same-cycle issue and leaves data untouched
    flush = 1'b1;
    cyc(); idle();
    for (int i = 1; i <= 3; i++) begin
      iss_en = 1'b1; iss_rd = 5'(i);
      cyc();
    end
    idle();
    check("fl_pre_cnt", {26'd0, busy_cnt}, 32'd3);
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd8;
    cyc(); idle(); rs1 = 5'd8; rs2 = 5'd3;
    #1 check("fl_cnt", {26'd0, busy_cnt}, 32'd0);
    check("fl_rdy8", {31'd0, r1_rdy}, 32'd1);
    check("fl_rdy3", {31'd0, r2_rdy}, 32'd1);
    rs1 = 5'd4;
    #1 check("fl_data4", r1, 32'h66);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      cyc();
      wen    = ($urandom_range(1, 0) == 1);
      rd     = 5'($urandom_range(31, 0));
      din    = $urandom;
      iss_en = ($urandom_range(4, 0) < 2);
      iss_rd = ($urandom_range(7, 0) == 0) ? rd : 5'($urandom_range(31, 0));
      flush  = ($urandom_range(29, 0) == 0);
      rs1    = ($urandom_range(3, 0) == 0) ? rd : 5'($urandom_range(31, 0));
      rs2    = ($urandom_range(3, 0) == 0) ? iss_rd : 5'($urandom_range(31, 0));
    end
    cyc(); idle();
    flush = 1'b1;
    cyc(); idle();

    // Fill every index, then async reset between edges
    for (int i = 1; i <= 31; i++) begin
      iss_en = 1'b1; iss_rd = 5'(i);
      cyc();
    end
    idle();
    check("fill_cnt", {26'd0, busy_cnt}, 32'd31);
    iss_en = 1'b1; iss_rd = 5'd0;
    cyc(); idle();
    check("fill_cnt0", {26'd0, busy_cnt}, 32'd31);
    rs1 = 5'd4; rs2 = 5'd17;
    #2 rst_n = 1'b0;
    #1 check("arst_cnt", {26'd0, busy_cnt}, 32'd0);
    check("arst_r4", r1, 32'd0);
    check("arst_rdy17", {31'd0, r2_rdy}, 32'd1);
    #1 rst_n = 1'b1;
    repeat (3) cyc();
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
